// File: rtl/i2s_pkg.sv
// Shared widths and sample type for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned FRAME_SLOTS = 32;
    localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int unsigned FRAME_W     = 2 * SAMPLE_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV clk cycles and flags the
// cycle on which each rising/falling transition is registered.
module bclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic rise_stb_c,
    output logic fall_stb_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             term_c;

    assign term_c     = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign rise_stb_c = term_c & ~bclk;
    assign fall_stb_c = term_c & bclk;

    // Half-period counter; bclk flips at terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (term_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo Philips I2S serializer with a one-entry input buffer.
// Each sample is sent on both channels; an empty buffer at frame load
// repeats the previous sample and pulses underrun.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);

    logic              fall_stb_c;
    logic              rise_stb_unused;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_next_c;
    logic              buf_full;
    sample_t           sample_buf;
    sample_t           last_sample;
    sample_t           load_word_c;
    logic [FRAME_W-1:0] frame_sr;
    logic              accept_c;
    logic              load_c;

    bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .bclk       (bclk),
        .rise_stb_c (rise_stb_unused),
        .fall_stb_c (fall_stb_c)
    );

    assign sample_ready = ~buf_full;
    assign accept_c     = sample_valid & ~buf_full;
    assign slot_next_c  = slot + SLOT_W'(1);
    // Loading on the fall into slot 1 gives the one-bit I2S data delay.
    assign load_c       = fall_stb_c & (slot == '0);
    assign load_word_c  = buf_full ? sample_buf : last_sample;

    // Slot counter, word select and frame shifter, all advanced on bclk fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot     <= '0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            frame_sr <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (fall_stb_c) begin
                slot  <= slot_next_c;
                lrclk <= slot_next_c[SLOT_W-1];
                if (load_c) begin
                    frame_sr <= {load_word_c, load_word_c};
                    sdata    <= load_word_c[SAMPLE_W-1];
                    underrun <= ~buf_full;
                end else begin
                    frame_sr <= frame_sr << 1;
                    sdata    <= frame_sr[FRAME_W-2];
                end
            end
        end
    end

    // One-entry holding buffer; drained by the frame load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full    <= 1'b0;
            sample_buf  <= '0;
            last_sample <= '0;
        end else begin
            if (load_c) begin
                last_sample <= load_word_c;
            end
            if (accept_c) begin
                sample_buf <= sample_in;
                buf_full   <= 1'b1;
            end else if (load_c) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: directed frame table plus randomized
// traffic against a time-indexed reference model.
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int unsigned CD     = 4;
    localparam int unsigned FRAME  = 64 * CD;
    localparam int          NT     = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    i2s_tx #(.CLK_DIV(CD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        send;
        logic [15:0] word;
        logic [15:0] exp_word;
        logic        exp_und;
    } vec_t;

    vec_t tbl [NT];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: time since reset release plus buffer contents.
    int          n        = 0;
    logic        m_full   = 1'b0;
    logic [15:0] m_buf    = 16'h0;
    logic [15:0] m_last   = 16'h0;
    logic [15:0] m_word   = 16'h0;
    logic        m_loaded = 1'b0;

    logic [15:0] cap_l = 16'h0;
    logic [15:0] cap_r = 16'h0;
    logic        cap_und = 1'b0;
    int          fidx = 0;
    logic        tbl_mode = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got %b expected %b", name, n, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s frame=%0d got %h expected %h", name, fidx, act, exp);
        end
    endtask

    function automatic int cur_slot();
        return (n / (2 * CD)) % 32;
    endfunction

    function automatic logic exp_sdata(input int s);
        if (!m_loaded) return 1'b0;
        if (s >= 1 && s <= 16) return m_word[16 - s];
        if (s >= 17) return m_word[32 - s];
        return m_word[0];
    endfunction

    task automatic check_reset_values();
        check("rst_bclk", bclk, 1'b0);
        check("rst_lrclk", lrclk, 1'b0);
        check("rst_sdata", sdata, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_ready", sample_ready, 1'b1);
    endtask

    task automatic model_reset();
        n = 0; m_full = 1'b0; m_buf = 16'h0; m_last = 16'h0;
        m_word = 16'h0; m_loaded = 1'b0;
    endtask

    // One clk: advance model, compare every output, capture serial words.
    task automatic step(output logic acc, output logic load);
        logic fall;
        logic full_before;
        int   s;
        acc = sample_valid && !m_full;
        @(posedge clk);
        n++;
        fall = ((n % (2 * CD)) == 0);
        s = cur_slot();
        load = fall && (s == 1);
        full_before = m_full;
        if (load) begin
            if (m_full) begin
                m_word = m_buf;
                m_full = 1'b0;
            end else begin
                m_word = m_last;
            end
            m_last = m_word;
            m_loaded = 1'b1;
        end
        if (acc) begin
            m_buf = sample_in;
            m_full = 1'b1;
        end
        #1;
        check("bclk", bclk, ((n / CD) % 2) == 1);
        check("lrclk", lrclk, s >= 16);
        check("sdata", sdata, exp_sdata(s));
        check("underrun", underrun, load && !full_before);
        check("ready", sample_ready, !m_full);
        if (fall) begin
            if (s >= 1 && s <= 16) cap_l = {cap_l[14:0], sdata};
            else                   cap_r = {cap_r[14:0], sdata};
            if (load) begin
                cap_und = underrun;
                fidx++;
            end
            if (s == 0 && tbl_mode && fidx >= 1 && fidx <= NT) begin
                check16("left_word", cap_l, tbl[fidx-1].exp_word);
                check16("right_word", cap_r, tbl[fidx-1].exp_word);
                check("frame_underrun", cap_und, tbl[fidx-1].exp_und);
            end
        end
    endtask

    task automatic run(input int cycles);
        logic a, l;
        for (int i = 0; i < cycles; i++) step(a, l);
    endtask

    initial begin
        logic a, l;
        int   guard;

        tbl[0] = '{1'b1, 16'hA5C3, 16'hA5C3, 1'b0};
        tbl[1] = '{1'b1, 16'h8000, 16'h8000, 1'b0};
        tbl[2] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b0};
        tbl[3] = '{1'b1, 16'h1234, 16'h1234, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 16'h1234, 1'b1};
        tbl[5] = '{1'b1, 16'h0001, 16'h0001, 1'b0};

        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Directed frames: each sample offered right after the previous load.
        tbl_mode = 1'b1;
        for (int k = 0; k < NT; k++) begin
            if (tbl[k].send) begin
                sample_valid = 1'b1;
                sample_in = tbl[k].word;
                guard = 0;
                do begin
                    step(a, l);
                    guard++;
                end while (!a && guard < FRAME + 8);
                if (!a) check("accept_timeout", 1'b0, 1'b1);
                sample_valid = 1'b0;
            end
            guard = 0;
            l = 1'b0;
            while (!l && guard < FRAME + 8) begin
                step(a, l);
                guard++;
            end
            if (!l) check("load_timeout", 1'b0, 1'b1);
        end
        run(FRAME);
        tbl_mode = 1'b0;

        // Random sparse traffic: mixes on-time samples and underruns.
        for (int i = 0; i < 30 * FRAME; i++) begin
            if (!sample_valid && $urandom_range(0, 299) == 0) begin
                sample_valid = 1'b1;
                sample_in = 16'($urandom);
            end
            step(a, l);
            if (a) sample_valid = 1'b0;
        end

        // valid held high: one accept per frame, buffer never overwritten.
        sample_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            sample_in = 16'($urandom);
            step(a, l);
        end

        // Reset at slot 20 with a pending sample in the buffer.
        guard = 0;
        while (cur_slot() != 20 && guard < FRAME + 8) begin
            sample_in = 16'($urandom);
            step(a, l);
            guard++;
        end
        if (cur_slot() != 20) check("slot20_timeout", 1'b0, 1'b1);
        check("pending_before_reset", sample_ready, 1'b0);
        sample_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;

        // First load after release lands at clk 8 and must underrun with zeros.
        run(7);
        step(a, l);
        check("first_load_at_8", l, 1'b1);
        check("first_load_underrun", underrun, 1'b1);
        check("first_load_sdata", sdata, 1'b0);
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Audio output serializer for the karaoke datapath: accepts processed signed 16-bit mono samples (e.g. the FIR compensation filter's output) over a ready/valid handshake, buffers one sample, and drives a standard Philips I2S stream (BCLK, LRCLK, SDATA) to the external DAC. Each mono sample is duplicated to left and right channels in a 32-slot frame. Underrun is handled by repeating the last sample and flagging it.

## Interface
- CLK_DIV, 4, clk cycles per BCLK half-period (≥2); BCLK period = 2·CLK_DIV clk cycles
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- sample_in  input  16  signed Q15 sample, two's complement
- sample_valid  input  1  sample_in valid this cycle
- sample_ready  output  1  = !buf_full; sample accepted on clk edge where valid && ready
- bclk  output  1  I2S bit clock (registered)
- lrclk  output  1  word select: 0 = left, 1 = right (registered)
- sdata  output  1  serial data, MSB first (registered)
- underrun  output  1  one-clk pulse when a frame load finds the buffer empty

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1; at terminal count bclk toggles. Toggle 0→1 = rise strobe, 1→0 = fall strobe. All I2S outputs change only on the fall-strobe cycle.
- Slot counter slot: 0..31, increments (wraps 31→0) on each fall strobe. lrclk = 0 for slots 0..15, 1 for slots 16..31.
- Holding buffer: 1 entry (buf, buf_full). Write on valid && ready sets buf_full.
- Frame load on the fall strobe entering slot 1:
  - buf_full=1: frame_sr ← {buf, buf}, last_sample ← buf, buf_full ← 0.
  - buf_full=0: frame_sr ← {last_sample, last_sample}, underrun pulses for that cycle.
- Shift: sdata ← frame_sr[31] on load; each later fall strobe shifts left by 1. Slots 1..16 carry left bits 15..0; slots 17..31 and next slot 0 carry right bits 15..0 (one-BCLK I2S data delay after each lrclk edge).
- Simultaneous accept and load with buffer empty: load uses last_sample (underrun pulses); accepted sample lands in buf for the next frame.
- Load with buffer full: ready is low that cycle; buffer empties and ready rises the next cycle.
- Widths: no arithmetic on samples; bits are transmitted verbatim. -32768 (16'h8000) sends 1 then fifteen 0s.

## Timing
- Reset values: bclk 0, lrclk 0, sdata 0, underrun 0, sample_ready 1 (buf_full 0), div_cnt 0, slot 0, last_sample 0, frame_sr 0.
- Reset mid-frame: all state cleared immediately; no partial-word completion; pending buffered sample discarded.
- First bclk rise at clk edge CLK_DIV after reset release; first fall at 2·CLK_DIV; that fall enters slot 1 and performs the first load.
- Frame period = 64·CLK_DIV clk cycles (256 at default). Exactly one load and at most one buffer drain per frame.
- Latency: sample accepted before a load cycle → its MSB on sdata in that load cycle; otherwise the next frame's load.
- sdata/lrclk stable across each bclk rising edge (changed CLK_DIV cycles earlier).

## Structure
- Package i2s_pkg: SAMPLE_W = 16, FRAME_SLOTS = 32, typedef logic signed [SAMPLE_W-1:0] sample_t.
- Sub-module bclk_gen: divider producing bclk, rise_stb, fall_stb; i2s_tx contains buffer, slot counter, frame shift register.

## Test plan
- Reset, no input, CLK_DIV=4: first load at clk 8 pulses underrun; sdata all 0; bclk period 8 clks; lrclk toggles every 128 clks.
- Send 16'hA5C3 before first load: slots 1..16 and 17..31,0 both show 1010010111000011 MSB first; sample_ready low from accept until load+1.
- Stream 16'h8000 then 16'h7FFF each frame: left/right words match exactly; no underrun pulses.
- Withhold input one frame after 16'h1234: that frame repeats 16'h1234, underrun pulses once at its load.
- valid held high continuously: exactly one accept per frame, buffer never overwritten, ready low while full.
- Assert reset_n low at slot 20: outputs go to reset values immediately; after release, timing restarts from clk 0 with last_sample = 0.
